// File: rtl/writeback.sv
// Final RV32I pipeline stage: load handshake, load alignment/extension,
// write-back value selection, register-file write port, error and retire tracking.
module writeback #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [4:0]  i_rd,
   input  logic        i_reg_write,
   input  logic [1:0]  i_reg_write_source_op,
   input  logic        i_mem_read,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_pc_plus4,
   input  logic [31:0] i_immediate,
   output logic        o_dmem_req,
   output logic [31:0] o_dmem_addr,
   input  logic        i_dmem_rvalid,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_stall,
   output logic        o_reg_write_wb,
   output logic [4:0]  o_rd_waddr,
   output logic [31:0] o_rd_wdata,
   output logic        o_err,
   output logic [31:0] o_retire_count
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nx;
   logic [7:0]  tmo_cnt;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_off;
   logic        ld_we;

   logic        accept;
   logic        misalign;
   logic        timeout;
   logic [31:0] sel_value;
   logic [31:0] load_value;

   assign accept  = i_valid && (state == IDLE);
   assign o_stall = (state == WAIT);

   always_comb begin
      misalign = 1'b0;
      case (i_funct3)
         3'b000, 3'b100: misalign = 1'b0;
         3'b001, 3'b101: misalign = i_alu_result[0];
         default:        misalign = (i_alu_result[1:0] != 2'b00);
      endcase
   end

   // Source op 01 on a non-load has no load data to offer; fall back to the ALU result.
   always_comb begin
      sel_value = i_alu_result;
      case (i_reg_write_source_op)
         2'b10:   sel_value = i_pc_plus4;
         2'b11:   sel_value = i_immediate;
         default: sel_value = i_alu_result;
      endcase
   end

   always_comb begin
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      lane_b     = i_dmem_rdata[8*ld_off +: 8];
      lane_h     = ld_off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
      load_value = i_dmem_rdata;
      case (ld_funct3)
         3'b000:  load_value = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_value = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_value = {24'h0, lane_b};
         3'b101:  load_value = {16'h0, lane_h};
         default: load_value = i_dmem_rdata;
      endcase
   end

   always_comb begin
      state_nx = state;
      timeout  = 1'b0;
      case (state)
         IDLE: if (accept && i_mem_read && !misalign) state_nx = WAIT;
         WAIT: begin
            if (i_dmem_rvalid) begin
               state_nx = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nx = IDLE;
               timeout  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_dmem_req     <= 1'b0;
         o_dmem_addr    <= '0;
         o_reg_write_wb <= 1'b0;
         o_rd_waddr     <= '0;
         o_rd_wdata     <= '0;
         o_err          <= 1'b0;
         o_retire_count <= '0;
         tmo_cnt        <= '0;
         ld_rd          <= '0;
         ld_funct3      <= '0;
         ld_off         <= '0;
         ld_we          <= 1'b0;
      end else begin
         o_dmem_req     <= 1'b0;
         o_reg_write_wb <= 1'b0;
         if (accept) begin
            if (i_mem_read) begin
               if (misalign) begin
                  o_err <= 1'b1;
               end else begin
                  o_dmem_req  <= 1'b1;
                  o_dmem_addr <= {i_alu_result[31:2], 2'b00};
                  ld_rd       <= i_rd;
                  ld_funct3   <= i_funct3;
                  ld_off      <= i_alu_result[1:0];
                  ld_we       <= i_reg_write;
                  tmo_cnt     <= '0;
               end
            end else begin
               o_rd_waddr     <= i_rd;
               o_rd_wdata     <= sel_value;
               o_reg_write_wb <= i_reg_write && (i_rd != 5'd0);
               o_retire_count <= o_retire_count + 32'd1;
            end
         end else if (state == WAIT) begin
            if (i_dmem_rvalid) begin
               o_rd_waddr     <= ld_rd;
               o_rd_wdata     <= load_value;
               o_reg_write_wb <= ld_we && (ld_rd != 5'd0);
               o_retire_count <= o_retire_count + 32'd1;
            end else if (timeout) begin
               o_err <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: doc/writeback.md
# writeback

Final pipeline stage of the RV32I core: accepts completed instructions from execute, performs the data-memory read handshake for loads, aligns and sign/zero-extends load data, selects the register write-back value and drives the register-file write port consumed by decode (`reg_write_wb`, `i_rd_waddr`, `i_rd_wdata`). It also stalls upstream while a load is outstanding, flags misaligned or timed-out loads, and counts retired instructions.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in WAIT before a load is abandoned; range 1..255.

Ports:
- `i_clk` in 1: clock, all state updates on rising edge.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: instruction from execute is present.
- `i_rd` in 5: destination register.
- `i_reg_write` in 1: instruction writes rd.
- `i_reg_write_source_op` in 2: 00 ALU result, 01 load data, 10 pc+4, 11 immediate.
- `i_mem_read` in 1: instruction is a load.
- `i_funct3` in 3: load width/sign.
- `i_alu_result` in 32: ALU result; also the load byte address.
- `i_pc_plus4` in 32: return address for JAL/JALR.
- `i_immediate` in 32: immediate for LUI.
- `o_dmem_req` out 1: load request pulse.
- `o_dmem_addr` out 32: word-aligned load address ({alu_result[31:2],2'b00}).
- `i_dmem_rvalid` in 1: read data valid.
- `i_dmem_rdata` in 32: read word.
- `o_stall` out 1: block is busy; upstream holds its instruction.
- `o_reg_write_wb` out 1: register-file write enable.
- `o_rd_waddr` out 5: write address.
- `o_rd_wdata` out 32: write data.
- `o_err` out 1: sticky misalign/timeout error.
- `o_retire_count` out 32: retired-instruction counter.

## Operation

- States: IDLE, WAIT. Reset state IDLE.
- Accept condition: `i_valid && state==IDLE`. In WAIT inputs are ignored.
- IDLE, accepted non-load: capture selected value per source op; next cycle `o_reg_write_wb`=1 for exactly one cycle if `i_reg_write && i_rd!=0`; retire count increments.
- IDLE, accepted load:
  - Misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]!=0): no request, no write, `o_err` set, stay IDLE, no retire.
  - Aligned: `o_dmem_req`=1 and `o_dmem_addr` valid for one cycle (registered), go WAIT; capture rd, funct3, addr[1:0].
- WAIT: `o_stall`=1. Timeout counter starts at 0, increments each WAIT cycle.
  - `i_dmem_rvalid`=1: select lane by addr[1:0] (byte lanes 0..3, halves at 0/2), extend per funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; 011/110/111 treated as LW. Register result, go IDLE, write pulse next cycle (rd!=0 and reg_write), retire increments.
  - Counter reaches TIMEOUT_CYCLES without rvalid: go IDLE, set `o_err`, no write, no retire. rvalid on the same cycle wins.
- `i_dmem_rvalid` in IDLE is ignored.
- Load data is written whenever `i_mem_read`=1, regardless of source op.
- `o_err` clears only on reset. `o_retire_count` wraps 0xFFFFFFFF -> 0.
- rd==0: never writes; retire still counts.

## Timing

- Reset values: state IDLE, `o_stall` 0, `o_dmem_req` 0, `o_dmem_addr` 0, `o_reg_write_wb` 0, `o_rd_waddr` 0, `o_rd_wdata` 0, `o_err` 0, `o_retire_count` 0, timeout counter 0.
- All outputs registered; `o_stall` = (state==WAIT).
- Non-load: accepted at edge N -> write asserted during cycle N..N+1; back-to-back accepts every cycle.
- Load: accepted at edge N -> req during cycle N..N+1, `o_stall` high from edge N; rvalid sampled at edge M>N -> write during cycle M..M+1, `o_stall` low after M. Minimum load occupancy 2 cycles.
- Reset asserted mid-WAIT: immediate return to IDLE, outstanding load discarded, no write.

## Test plan

- ADDI result 0x0000002A, rd=5, source 00 -> one-cycle write rd=5 data 0x2A next cycle; retire 0->1.
- Load LB, addr 0x1003, rdata 0x80FF1234 after 3 WAIT cycles -> req addr 0x1000, stall 3 cycles, write 0xFFFFFF80; LBU same -> 0x00000080.
- LH addr 0x2001 -> no req, no write, `o_err`=1 persists; next ADD still writes normally.
- TIMEOUT_CYCLES=4, no rvalid -> stall exactly 4 cycles, `o_err`=1, no write; rvalid on cycle 4 instead -> write occurs, no error.
- JAL rd=0, pc+4 0x104 -> no write, retire increments; JAL rd=1 -> write 0x104.
- Reset pulse during WAIT -> outputs return to reset values, late rvalid ignored.
